// File: rtl/sram_responder_if.sv
// Initiator-side SRAM control/address pins as seen by the responder.
// All control lines are active-low; the data bus stays a plain inout port.
interface sram_responder_if #(parameter int ADDR_W = 18);
  logic [ADDR_W-1:0] i_sram_addr;
  logic              i_ce, i_we, i_oe, i_lb, i_ub;

  modport master (output i_sram_addr, i_ce, i_we, i_oe, i_lb, i_ub);
  modport slave  (input  i_sram_addr, i_ce, i_we, i_oe, i_lb, i_ub);
endinterface

// File: rtl/sram_responder.sv
// Pin-level 256K x 16 asynchronous SRAM model with configurable read latency,
// minimum write-pulse checking, access counters and a sticky protocol-error flag.
module sram_responder #(
  parameter int ADDR_W    = 18,
  parameter int READ_LAT  = 2,
  parameter int WRITE_MIN = 2,
  parameter     INIT_FILE = ""
) (
  input  logic               i_clk,
  input  logic               i_rst,
  sram_responder_if.slave    bus,
  inout  wire  [15:0]        io_sram_dq,
  output logic [2:0]         o_state,
  output logic               o_dq_oe,
  output logic [15:0]        o_rd_cnt,
  output logic [15:0]        o_wr_cnt,
  output logic               o_err
);
  localparam int LW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam int PW = $clog2(WRITE_MIN + 1);
  localparam logic [LW-1:0] WAIT_LD   = LW'(READ_LAT - 1);
  localparam logic [PW-1:0] PULSE_MIN = PW'(WRITE_MIN);

  typedef enum logic [2:0] {
    IDLE = 3'd0, RD_WAIT = 3'd1, RD_DRIVE = 3'd2, WR_ACT = 3'd3, WR_COMMIT = 3'd4
  } state_t;

  logic [15:0] mem [0:(1<<ADDR_W)-1];

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_lb, r_ub;
  logic [15:0]         r_wdata, r_rd_data;
  logic [LW-1:0]       r_wait;
  logic [PW-1:0]       r_pulse;
  logic                r_oe_lo, r_oe_hi, r_dq_oe;
  logic [15:0]         r_rd_cnt, r_wr_cnt;
  logic                r_err;

  logic w_wr_req, w_rd_req, w_rd_same, w_in_read, w_load, w_drop;

  assign w_wr_req  = !bus.i_ce && !bus.i_we;
  assign w_rd_req  = !bus.i_ce &&  bus.i_we && !bus.i_oe;
  assign w_rd_same = (bus.i_sram_addr == r_addr) && (bus.i_lb == r_lb) && (bus.i_ub == r_ub);
  assign w_in_read = (r_state == RD_WAIT) || (r_state == RD_DRIVE);

  // w_load: this edge enters RD_DRIVE; the address on the pins is always the one to fetch.
  always_comb begin
    w_load = 1'b0;
    w_drop = 1'b0;
    if (r_state == IDLE && !w_wr_req && w_rd_req && READ_LAT == 1) w_load = 1'b1;
    if (w_in_read && w_rd_req && !w_rd_same && READ_LAT == 1)      w_load = 1'b1;
    if (r_state == RD_WAIT && w_rd_req && w_rd_same && r_wait == '0) w_load = 1'b1;
    if (w_in_read && (!w_rd_req || !w_rd_same))                      w_drop = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_lb     <= 1'b0;
      r_ub     <= 1'b0;
      r_wdata  <= '0;
      r_wait   <= '0;
      r_pulse  <= '0;
      r_wr_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_wr_req) begin
            r_addr  <= bus.i_sram_addr;
            r_lb    <= bus.i_lb;
            r_ub    <= bus.i_ub;
            r_wdata <= io_sram_dq;
            r_pulse <= PW'(1);
            r_state <= WR_ACT;
          end else if (w_rd_req) begin
            r_addr  <= bus.i_sram_addr;
            r_lb    <= bus.i_lb;
            r_ub    <= bus.i_ub;
            r_wait  <= WAIT_LD;
            r_state <= w_load ? RD_DRIVE : RD_WAIT;
          end
        end
        RD_WAIT, RD_DRIVE: begin
          if (!w_rd_req) begin
            r_state <= IDLE;
          end else if (!w_rd_same) begin
            r_addr  <= bus.i_sram_addr;
            r_lb    <= bus.i_lb;
            r_ub    <= bus.i_ub;
            r_wait  <= WAIT_LD;
            r_state <= w_load ? RD_DRIVE : RD_WAIT;
          end else if (r_state == RD_WAIT) begin
            if (w_load) r_state <= RD_DRIVE;
            else        r_wait  <= r_wait - LW'(1);
          end
        end
        WR_ACT: begin
          if (w_wr_req) begin
            r_wdata <= io_sram_dq;
            r_lb    <= bus.i_lb;
            r_ub    <= bus.i_ub;
            // A moving address restarts the pulse; the old location is dropped.
            if (bus.i_sram_addr != r_addr) begin
              r_err   <= 1'b1;
              r_addr  <= bus.i_sram_addr;
              r_pulse <= PW'(1);
            end else if (r_pulse != PULSE_MIN) begin
              r_pulse <= r_pulse + PW'(1);
            end
          end else if (r_pulse >= PULSE_MIN) begin
            r_state <= WR_COMMIT;
          end else begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end
        end
        WR_COMMIT: begin
          r_wr_cnt <= r_wr_cnt + 16'd1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rd_data <= '0;
      r_oe_lo   <= 1'b0;
      r_oe_hi   <= 1'b0;
      r_dq_oe   <= 1'b0;
      r_rd_cnt  <= '0;
    end else if (w_load) begin
      r_rd_data <= mem[bus.i_sram_addr];
      r_oe_lo   <= !bus.i_lb;
      r_oe_hi   <= !bus.i_ub;
      r_dq_oe   <= !(bus.i_lb && bus.i_ub);
      r_rd_cnt  <= r_rd_cnt + 16'd1;
    end else if (w_drop) begin
      r_oe_lo   <= 1'b0;
      r_oe_hi   <= 1'b0;
      r_dq_oe   <= 1'b0;
    end
  end

  // Memory has no reset; an async reset during WR_COMMIT leaves r_state IDLE, so nothing lands.
  always_ff @(posedge i_clk) begin
    if (r_state == WR_COMMIT) begin
      if (!r_lb) mem[r_addr][7:0]  <= r_wdata[7:0];
      if (!r_ub) mem[r_addr][15:8] <= r_wdata[15:8];
    end
  end

  assign io_sram_dq[7:0]  = r_oe_lo ? r_rd_data[7:0]  : 8'hzz;
  assign io_sram_dq[15:8] = r_oe_hi ? r_rd_data[15:8] : 8'hzz;

  assign o_state  = r_state;
  assign o_dq_oe  = r_dq_oe;
  assign o_rd_cnt = r_rd_cnt;
  assign o_wr_cnt = r_wr_cnt;
  assign o_err    = r_err;
endmodule

// File: tb/tb_sram_responder.sv
// Scoreboarded bench: read requests push the expected edge and data, a monitor
// pops on each read completion and checks latency, lane enables and held data.
module tb_sram_responder;
  localparam int AW = 18, RL = 2, WM = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_responder_if #(.ADDR_W(AW)) bus ();
  wire  [15:0] dq;
  logic        tb_drv = 1'b0;
  logic [15:0] tb_dq  = '0;
  assign dq = tb_drv ? tb_dq : 16'hzzzz;

  logic [2:0]  st;
  logic        dq_oe, err;
  logic [15:0] rdc, wrc;

  sram_responder #(.ADDR_W(AW), .READ_LAT(RL), .WRITE_MIN(WM), .INIT_FILE("")) dut (
    .i_clk(clk), .i_rst(rst_n), .bus(bus), .io_sram_dq(dq),
    .o_state(st), .o_dq_oe(dq_oe), .o_rd_cnt(rdc), .o_wr_cnt(wrc), .o_err(err));

  typedef struct { int cyc; logic [15:0] data; logic lb, ub; } rd_t;
  rd_t         sbq[$];
  logic [15:0] mem_m [int];
  int          exp_rd = 0, exp_wr = 0, exp_err = 0;
  int          total = 0, bad = 0;
  int          cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_bus();
    bus.i_ce = 1'b1; bus.i_we = 1'b1; bus.i_oe = 1'b1; tb_drv = 1'b0;
  endtask

  function automatic logic [15:0] model_rd(input int a);
    return mem_m.exists(a) ? mem_m[a] : 16'h0000;
  endfunction

  // Start a read: data is due on the edge READ_LAT after the next one.
  task automatic rd_start(input int a, input bit lb, input bit ub);
    rd_t e;
    bus.i_sram_addr = AW'(a); bus.i_lb = lb; bus.i_ub = ub;
    bus.i_ce = 1'b0; bus.i_we = 1'b1; bus.i_oe = 1'b0;
    e.cyc = cyc + 1 + RL; e.data = model_rd(a); e.lb = lb; e.ub = ub;
    sbq.push_back(e);
    exp_rd++;
  endtask

  task automatic rd(input int a, input bit lb, input bit ub, input int hold);
    rd_start(a, lb, ub);
    repeat (RL + hold) tick();
    idle_bus();
    tick();
    @(negedge clk);
    chk("rd_release_oe", dq_oe, 0);
  endtask

  task automatic wr(input int a, input logic [15:0] d, input bit lb, input bit ub, input int n);
    logic [15:0] old;
    bus.i_sram_addr = AW'(a); bus.i_lb = lb; bus.i_ub = ub;
    tb_dq = d; tb_drv = 1'b1;
    bus.i_ce = 1'b0; bus.i_we = 1'b0; bus.i_oe = 1'b1;
    repeat (n) tick();
    idle_bus();
    if (n >= WM) begin
      old = model_rd(a);
      mem_m[a] = {ub ? old[15:8] : d[15:8], lb ? old[7:0] : d[7:0]};
      exp_wr++;
    end else begin
      exp_err = 1;
    end
    repeat (2) tick();
  endtask

  // Monitor: a read completion is an increment of o_rd_cnt.
  initial begin : mon
    logic [15:0] last;
    logic [15:0] mask;
    rd_t cur;
    bit have;
    last = '0; have = 1'b0; mask = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last = '0; have = 1'b0;
      end else begin
        if (rdc != last) begin
          last = rdc;
          if (sbq.size() == 0) begin
            chk("rd_unexpected", 1, 0);
          end else begin
            cur  = sbq.pop_front();
            have = 1'b1;
            mask = {cur.ub ? 8'h00 : 8'hff, cur.lb ? 8'h00 : 8'hff};
            chk("rd_latency", cyc, cur.cyc);
            chk("rd_lane_oe", dq_oe, (cur.lb && cur.ub) ? 0 : 1);
          end
        end
        if (have && dq_oe) chk("rd_data", dq & mask, cur.data & mask);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    int a, op;
    bus.i_sram_addr = '0; bus.i_lb = 1'b0; bus.i_ub = 1'b0;
    idle_bus();
    repeat (3) tick();
    @(negedge clk);
    chk("rst_state", st, 0);
    chk("rst_oe", dq_oe, 0);
    chk("rst_rdc", rdc, 0);
    chk("rst_wrc", wrc, 0);
    chk("rst_err", err, 0);
    tick(); rst_n = 1'b1; tick();

    // basic read latency and release
    wr('h10, 16'hBEEF, 0, 0, 2);
    rd('h10, 0, 0, 2);
    chk("rdc_after_first", rdc, 1);

    // full then high-byte write merge
    wr('h20, 16'h1234, 0, 0, 2);
    wr('h20, 16'hAB99, 1, 0, 2);
    rd('h20, 0, 0, 1);
    chk("merge_wrc", wrc, exp_wr);
    chk("merge_err", err, 0);

    // too-short write pulse
    wr('h30, 16'h5555, 0, 0, 2);
    wr('h30, 16'h9999, 0, 0, 1);
    chk("short_err", err, 1);
    chk("short_wrc", wrc, exp_wr);
    rd('h30, 0, 0, 1);

    // address change while driving
    wr('h11, 16'hC0DE, 0, 0, 2);
    rd_start('h10, 0, 0);
    repeat (RL + 1) tick();
    rd_start('h11, 0, 0);
    exp_rd--;
    exp_rd++;
    tick();
    @(negedge clk);
    chk("chg_oe_drop", dq_oe, 0);
    repeat (RL) tick();
    idle_bus();
    tick();
    chk("chg_rdc", rdc, exp_rd);

    // write and output enable together: write wins, bus never driven
    bus.i_sram_addr = AW'('h40); bus.i_lb = 1'b0; bus.i_ub = 1'b0;
    tb_dq = 16'h7777; tb_drv = 1'b1;
    bus.i_ce = 1'b0; bus.i_we = 1'b0; bus.i_oe = 1'b0;
    repeat (2) begin
      tick();
      @(negedge clk);
      chk("weoe_no_drive", dq_oe, 0);
      chk("weoe_state", st, 3);
    end
    idle_bus();
    tick();
    @(negedge clk);
    chk("weoe_commit_state", st, 4);
    tick();
    mem_m['h40] = 16'h7777; exp_wr++;
    chk("weoe_wrc", wrc, exp_wr);
    rd('h40, 0, 0, 1);

    // reset while driving a read
    rd_start('h10, 0, 0);
    repeat (RL + 1) tick();
    @(negedge clk);
    chk("pre_rst_drive", st, 2);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_rd_oe", dq_oe, 0);
    chk("rst_rd_state", st, 0);
    chk("rst_rd_rdc", rdc, 0);
    chk("rst_rd_wrc", wrc, 0);
    chk("rst_rd_err", err, 0);
    idle_bus();
    repeat (2) tick();
    rst_n = 1'b1;
    exp_rd = 0; exp_wr = 0; exp_err = 0;
    tick();

    // reset in the middle of a write pulse abandons it
    bus.i_sram_addr = AW'('h20); bus.i_lb = 1'b0; bus.i_ub = 1'b0;
    tb_dq = 16'hFFFF; tb_drv = 1'b1;
    bus.i_ce = 1'b0; bus.i_we = 1'b0; bus.i_oe = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk("pre_rst_wr", st, 3);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_wr_state", st, 0);
    idle_bus();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    rd('h20, 0, 0, 1);
    chk("post_rst_rdc", rdc, 1);
    chk("post_rst_wrc", wrc, 0);
    exp_rd = 1;

    // randomized traffic over a small preloaded address window
    for (int i = 0; i < 8; i++) wr('h100 + i, 16'($urandom), 0, 0, 2);
    for (int i = 0; i < 40; i++) begin
      a  = 'h100 + $urandom_range(0, 7);
      op = $urandom_range(0, 4);
      if (op < 3) rd(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 3));
      else        wr(a, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(1, 3));
    end

    repeat (3) tick();
    chk("final_rdc", rdc, exp_rd);
    chk("final_wrc", wrc, exp_wr);
    chk("final_err", err, exp_err);
    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
